// File: rtl/arb_pkg.sv
// Shared types, defaults and helper functions for the single-lock round-robin arbiter.
package arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } state_e;

  localparam int DEF_N_REQ   = 4;
  localparam int DEF_TIMEOUT = 255;
  localparam int MAX_REQ     = 16;

  // Index width; never below 1 so a 1-bit owner field always exists.
  function automatic int clog2(input int value);
    int width;
    width = 0;
    while ((1 << width) < value) width++;
    return (width < 1) ? 1 : width;
  endfunction

  // First set request at or after ptr, wrapping modulo n.
  function automatic logic [3:0] rr_pick(input logic [MAX_REQ-1:0] req_vec,
                                         input logic [3:0] ptr,
                                         input int n);
    logic [3:0] pick;
    int idx;
    pick = ptr;
    for (int i = MAX_REQ - 1; i >= 0; i--) begin
      if (i < n) begin
        idx = (int'(ptr) + i) % n;
        if (req_vec[idx]) pick = idx[3:0];
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/sr_toggle_cell.sv
// SR state bit built on a toggle flop: T flips Q only when S finds it clear or R finds it set.
module sr_toggle_cell (
  input  logic clk,
  input  logic rst,
  input  logic s,
  input  logic r,
  output logic q,
  output logic q_bar
);

  logic q_q;
  logic t_d;

  assign t_d = (s & ~q_q) | (r & q_q);

  always_ff @(posedge clk) begin
    if (rst) q_q <= 1'b0;
    else     q_q <= q_q ^ t_d;
  end

  assign q     = q_q;
  assign q_bar = ~q_q;

endmodule

// File: rtl/sr_lock_arbiter.sv
// Round-robin arbiter for one shared lock bit with owner release and optional hold timeout.
module sr_lock_arbiter
  import arb_pkg::*;
#(
  parameter int N_REQ   = DEF_N_REQ,
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int TW      = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ-1:0]        rel,
  output logic [N_REQ-1:0]        gnt,
  output logic                    busy,
  output logic [clog2(N_REQ)-1:0] owner,
  output logic                    timeout_pulse,
  output logic [TW-1:0]           hold_cnt
);

  localparam int IW = clog2(N_REQ);
  localparam logic [TW-1:0] TO_LAST = TW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
  localparam logic [TW-1:0] CNT_MAX = {TW{1'b1}};

  state_e            state_q, state_d;
  logic [N_REQ-1:0]  gnt_q, gnt_d;
  logic [IW-1:0]     owner_q, owner_d;
  logic [IW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [TW-1:0]     hold_cnt_q, hold_cnt_d;
  logic              timeout_q, timeout_d;

  logic              lock_q, lock_free;
  logic              grant_ev, rel_ev, to_ev;
  logic [MAX_REQ-1:0] req_ext;
  logic [IW-1:0]     next_ptr;

  always_comb begin
    req_ext = '0;
    req_ext[N_REQ-1:0] = req;
  end

  // The lock bit's own complement gates new grants, so a grant can never overlap a held lock.
  assign grant_ev = (state_q == IDLE) & lock_free & (|req);
  assign rel_ev   = (state_q == OWNED) & rel[owner_q];
  assign to_ev    = (state_q == OWNED) & (TIMEOUT != 0) & (hold_cnt_q == TO_LAST) & ~rel_ev;
  assign next_ptr = (int'(owner_q) == N_REQ - 1) ? '0 : owner_q + IW'(1);

  sr_toggle_cell u_lock (
    .clk   (clk),
    .rst   (rst),
    .s     (grant_ev),
    .r     (rel_ev | to_ev),
    .q     (lock_q),
    .q_bar (lock_free)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant_ev) state_d = OWNED;
      OWNED:   if (rel_ev || to_ev) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    gnt_d      = gnt_q;
    owner_d    = owner_q;
    rr_ptr_d   = rr_ptr_q;
    hold_cnt_d = hold_cnt_q;
    timeout_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_ev) begin
          owner_d        = IW'(rr_pick(req_ext, 4'(rr_ptr_q), N_REQ));
          gnt_d          = '0;
          gnt_d[owner_d] = 1'b1;
          hold_cnt_d     = '0;
        end
      end
      OWNED: begin
        if (hold_cnt_q != CNT_MAX) hold_cnt_d = hold_cnt_q + TW'(1);
        if (rel_ev || to_ev) begin
          gnt_d     = '0;
          rr_ptr_d  = next_ptr;
          timeout_d = to_ev;
        end
      end
      default: gnt_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_q      <= '0;
      owner_q    <= '0;
      rr_ptr_q   <= '0;
      hold_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      gnt_q      <= gnt_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      hold_cnt_q <= hold_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  assign gnt           = gnt_q;
  assign busy          = lock_q;
  assign owner         = owner_q;
  assign timeout_pulse = timeout_q;
  assign hold_cnt      = hold_cnt_q;

endmodule

// File: tb/tb_sr_lock_arbiter.sv
// Directed scenarios plus randomized traffic checked against a behavioural lock model.
module tb_sr_lock_arbiter;

  localparam int N  = 4;
  localparam int TO = 8;
  localparam int TW = 8;

  logic          clk;
  logic          rst;
  logic [N-1:0]  req;
  logic [N-1:0]  rel;
  logic [N-1:0]  gnt;
  logic          busy;
  logic [1:0]    owner;
  logic          timeout_pulse;
  logic [TW-1:0] hold_cnt;

  int n_checks;
  int n_fail;

  // Reference model state
  int m_owned;
  int m_owner;
  int m_ptr;
  int m_cnt;
  int m_to;

  sr_lock_arbiter #(
    .N_REQ   (N),
    .TIMEOUT (TO),
    .TW      (TW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req           (req),
    .rel           (rel),
    .gnt           (gnt),
    .busy          (busy),
    .owner         (owner),
    .timeout_pulse (timeout_pulse),
    .hold_cnt      (hold_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock edge of the lock as described: grant from IDLE, leave OWNED on owner release or timeout.
  task automatic model_edge(input logic [N-1:0] r, input logic [N-1:0] l, input logic s);
    int rel_hit;
    int tout;
    if (s) begin
      m_owned = 0; m_owner = 0; m_ptr = 0; m_cnt = 0; m_to = 0;
    end else if (m_owned == 0) begin
      m_to = 0;
      if (r != 0) begin
        for (int i = N - 1; i >= 0; i--)
          if (r[(m_ptr + i) % N]) m_owner = (m_ptr + i) % N;
        m_owned = 1;
        m_cnt   = 0;
      end
    end else begin
      rel_hit = int'(l[m_owner]);
      tout    = (m_cnt == TO - 1 && rel_hit == 0) ? 1 : 0;
      m_cnt   = (m_cnt + 1 > (1 << TW) - 1) ? (1 << TW) - 1 : m_cnt + 1;
      m_to    = tout;
      if (rel_hit != 0 || tout != 0) begin
        m_owned = 0;
        m_ptr   = (m_owner + 1) % N;
      end
    end
  endtask

  task automatic cyc(input logic [N-1:0] r, input logic [N-1:0] l, input logic s);
    logic [N-1:0] exp_gnt;
    req = r; rel = l; rst = s;
    @(posedge clk);
    model_edge(r, l, s);
    #1;
    exp_gnt = (m_owned != 0) ? N'(1 << m_owner) : '0;
    check_eq("gnt", 32'(gnt), 32'(exp_gnt));
    check_eq("busy", 32'(busy), 32'(m_owned));
    check_eq("owner", 32'(owner), 32'(m_owner));
    check_eq("hold_cnt", 32'(hold_cnt), 32'(m_cnt));
    check_eq("timeout_pulse", 32'(timeout_pulse), 32'(m_to));
    check_eq("legal_busy_gnt", 32'(busy && (gnt == '0)), 32'd0);
    $display("cyc req=%b rel=%b rst=%b -> gnt=%b busy=%b owner=%0d hold=%0d to=%b",
             r, l, s, gnt, busy, owner, hold_cnt, timeout_pulse);
  endtask

  initial begin
    logic [N-1:0] rr;
    logic [N-1:0] rl;
    logic         rs;
    int           pick;
    n_checks = 0; n_fail = 0;
    m_owned = 0; m_owner = 0; m_ptr = 0; m_cnt = 0; m_to = 0;
    req = '0; rel = '0; rst = 1'b1;

    // Idle after reset
    cyc(4'b0000, 4'b0000, 1'b1);
    for (int i = 0; i < 10; i++) cyc(4'b0000, 4'b0000, 1'b0);
    check_eq("t1_gnt_idle", 32'(gnt), 32'd0);

    // First grant, owner release, gap, then round-robin hand-over to requester 3
    cyc(4'b1010, 4'b0000, 1'b0);
    check_eq("t2_gnt", 32'(gnt), 32'b0010);
    check_eq("t2_owner", 32'(owner), 32'd1);
    for (int i = 0; i < 4; i++) cyc(4'b1010, 4'b0000, 1'b0);
    cyc(4'b1010, 4'b0010, 1'b0);
    check_eq("t2_gap_busy", 32'(busy), 32'd0);
    cyc(4'b1010, 4'b0000, 1'b0);
    check_eq("t2_gnt3", 32'(gnt), 32'b1000);
    check_eq("t2_owner3", 32'(owner), 32'd3);
    cyc(4'b0000, 4'b1000, 1'b0);

    // All requesting: order 0,1,2,3,0 with one idle cycle between owners
    cyc(4'b0000, 4'b0000, 1'b1);
    for (int k = 0; k < 5; k++) begin
      cyc(4'b1111, 4'b0000, 1'b0);
      check_eq("t3_owner", 32'(owner), 32'(k % N));
      cyc(4'b1111, 4'b0000, 1'b0);
      cyc(4'b1111, 4'b0000, 1'b0);
      cyc(4'b1111, N'(1 << (k % N)), 1'b0);
      check_eq("t3_gap", 32'(busy), 32'd0);
    end

    // Timeout with a single persistent requester
    cyc(4'b0000, 4'b0000, 1'b1);
    for (int i = 0; i < 8; i++) begin
      cyc(4'b0001, 4'b0000, 1'b0);
      check_eq("t4_held", 32'(gnt), 32'b0001);
    end
    cyc(4'b0001, 4'b0000, 1'b0);
    check_eq("t4_dropped", 32'(gnt), 32'd0);
    check_eq("t4_pulse", 32'(timeout_pulse), 32'd1);
    cyc(4'b0001, 4'b0000, 1'b0);
    check_eq("t4_regrant", 32'(gnt), 32'b0001);
    check_eq("t4_pulse_off", 32'(timeout_pulse), 32'd0);

    // Non-owner release ignored; owner release on the timeout edge wins
    cyc(4'b0000, 4'b0000, 1'b1);
    cyc(4'b0100, 4'b0000, 1'b0);
    cyc(4'b0100, 4'b0001, 1'b0);
    check_eq("t5_nonowner", 32'(gnt), 32'b0100);
    for (int i = 0; i < 6; i++) cyc(4'b0100, 4'b0000, 1'b0);
    check_eq("t5_cnt", 32'(hold_cnt), 32'(TO - 1));
    cyc(4'b0100, 4'b0100, 1'b0);
    check_eq("t5_released", 32'(busy), 32'd0);
    check_eq("t5_no_pulse", 32'(timeout_pulse), 32'd0);

    // Reset mid-ownership, then the pointer restarts from 0
    cyc(4'b0000, 4'b0000, 1'b1);
    cyc(4'b0100, 4'b0000, 1'b0);
    for (int i = 0; i < 5; i++) cyc(4'b0100, 4'b0000, 1'b0);
    check_eq("t6_cnt5", 32'(hold_cnt), 32'd5);
    cyc(4'b0110, 4'b0000, 1'b1);
    check_eq("t6_rst_gnt", 32'(gnt), 32'd0);
    cyc(4'b0110, 4'b0000, 1'b0);
    check_eq("t6_owner1", 32'(owner), 32'd1);

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      rr   = N'($urandom_range(0, 15));
      pick = $urandom_range(0, 19);
      if (pick < 2)       rl = N'(1 << m_owner);
      else if (pick == 2) rl = N'($urandom_range(0, 15));
      else                rl = '0;
      rs = ($urandom_range(0, 99) == 0);
      cyc(rr, rl, rs);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
